// File: rtl/sram_arb_pkg.sv
// Shared types and sizing helpers for the SRAM arbiter: FSM state encoding,
// default bus widths and the wait-counter width rule.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        REC   = 2'd3
    } state_e;

    localparam int DEF_ADDR_W  = 18;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RD_WAIT = 2;
    localparam int DEF_WR_WAIT = 2;

    // The counter holds WAIT-1 at most; never let the width collapse to zero.
    function automatic int cnt_width(input int rd_wait, input int wr_wait);
        int max_wait;
        max_wait = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        return (max_wait < 2) ? 1 : $clog2(max_wait);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_RD_WAIT, DEF_WR_WAIT);

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates a single asynchronous SRAM between a playback reader and a record
// writer, producing registered strobes with fixed access timing.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_WAIT  = DEF_WR_WAIT,
    parameter int MAX_SKIP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic              busy
);

    localparam int CNT_W  = cnt_width(RD_WAIT, WR_WAIT);
    localparam int SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
    localparam logic [CNT_W-1:0]  RD_LOAD  = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0]  WR_LOAD  = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [SKIP_W-1:0]  skip_cnt_r, skip_s;
    logic               byte_n_r, byte_n_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [DATA_W-1:0]  dq_o_s, rd_data_s;
    logic               dq_oe_s, ce_n_s, oe_n_s, we_n_s;
    logic               rd_valid_s, wr_ack_s, busy_s;
    logic               grant_rd_s, grant_wr_s;

    assign sram_lb_n = byte_n_r;
    assign sram_ub_n = byte_n_r;

    // Next-state, arbitration and next output values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        skip_s     = skip_cnt_r;
        byte_n_s   = byte_n_r;
        addr_s     = sram_addr;
        dq_o_s     = sram_dq_o;
        dq_oe_s    = sram_dq_oe;
        ce_n_s     = sram_ce_n;
        oe_n_s     = sram_oe_n;
        we_n_s     = sram_we_n;
        rd_data_s  = rd_data;
        rd_valid_s = 1'b0;
        wr_ack_s   = 1'b0;
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (rd_req && wr_req) begin
                    if (skip_cnt_r == SKIP_MAX) begin
                        grant_wr_s = 1'b1;
                    end else begin
                        grant_rd_s = 1'b1;
                        skip_s     = skip_cnt_r + SKIP_W'(1);
                    end
                end else if (rd_req) begin
                    grant_rd_s = 1'b1;
                end else if (wr_req) begin
                    grant_wr_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end

                if (grant_rd_s) begin
                    state_s  = READ;
                    cnt_s    = RD_LOAD;
                    addr_s   = rd_addr;
                    dq_oe_s  = 1'b0;
                    ce_n_s   = 1'b0;
                    oe_n_s   = 1'b0;
                    we_n_s   = 1'b1;
                    byte_n_s = 1'b0;
                end else if (grant_wr_s) begin
                    state_s  = WRITE;
                    cnt_s    = WR_LOAD;
                    skip_s   = {SKIP_W{1'b0}};
                    addr_s   = wr_addr;
                    dq_o_s   = wr_data;
                    dq_oe_s  = 1'b1;
                    ce_n_s   = 1'b0;
                    oe_n_s   = 1'b1;
                    we_n_s   = 1'b0;
                    byte_n_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s    = REC;
                    rd_data_s  = sram_dq_i;
                    rd_valid_s = 1'b1;
                    ce_n_s     = 1'b1;
                    oe_n_s     = 1'b1;
                    byte_n_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            WRITE: begin
                // Data and drive enable stay up through REC for hold after WE rises.
                if (cnt_r == CNT_ZERO) begin
                    state_s  = REC;
                    wr_ack_s = 1'b1;
                    ce_n_s   = 1'b1;
                    we_n_s   = 1'b1;
                    byte_n_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            REC: begin
                state_s = IDLE;
                dq_oe_s = 1'b0;
            end
            default: begin
                state_s  = IDLE;
                dq_oe_s  = 1'b0;
                ce_n_s   = 1'b1;
                oe_n_s   = 1'b1;
                we_n_s   = 1'b1;
                byte_n_s = 1'b1;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            skip_cnt_r <= {SKIP_W{1'b0}};
            byte_n_r   <= 1'b1;
            sram_addr  <= {ADDR_W{1'b0}};
            sram_dq_o  <= {DATA_W{1'b0}};
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            rd_data    <= {DATA_W{1'b0}};
            rd_valid   <= 1'b0;
            wr_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            skip_cnt_r <= skip_s;
            byte_n_r   <= byte_n_s;
            sram_addr  <= addr_s;
            sram_dq_o  <= dq_o_s;
            sram_dq_oe <= dq_oe_s;
            sram_ce_n  <= ce_n_s;
            sram_oe_n  <= oe_n_s;
            sram_we_n  <= we_n_s;
            rd_data    <= rd_data_s;
            rd_valid   <= rd_valid_s;
            wr_ack     <= wr_ack_s;
            busy       <= busy_s;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model and
// hand-computed expectations for timing, arbitration order and data.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req;
    logic [17:0] rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, wr_ack;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:262143];
    byte         grants[$];
    logic        prev_oe_n, prev_we_n;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(18), .DATA_W(16), .RD_WAIT(2), .WR_WAIT(2), .MAX_SKIP(2)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
        .busy(busy)
    );

    // SRAM model: drives read data mid-cycle, stores writes while WE is low.
    initial begin
        sram_dq_i = 16'h0000;
        forever begin
            @(negedge clk);
            if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_o;
            sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
        end
    end

    // Bus invariants and grant log, sampled mid-cycle.
    initial begin
        prev_oe_n = 1'b1;
        prev_we_n = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (!sram_oe_n && !sram_we_n) begin
                    failures++;
                    $display("FAIL oe_we_overlap: oe_n=%b we_n=%b, required not both 0", sram_oe_n, sram_we_n);
                end
                checks++;
                if (sram_dq_oe && !sram_oe_n) begin
                    failures++;
                    $display("FAIL dq_oe_vs_oe: dq_oe=%b oe_n=%b, required dq_oe=0 while oe_n=0", sram_dq_oe, sram_oe_n);
                end
                if (!sram_oe_n && prev_oe_n) grants.push_back(8'h52);
                if (!sram_we_n && prev_we_n) grants.push_back(8'h57);
            end
            prev_oe_n = sram_oe_n;
            prev_we_n = sram_we_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            failures++;
            $display("FAIL %s_strobes: got %b, required 11111", tag,
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        checks++;
        if ({sram_dq_oe, rd_valid, wr_ack, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL %s_ctrl: dq_oe/rd_valid/wr_ack/busy=%b, required 0000", tag,
                     {sram_dq_oe, rd_valid, wr_ack, busy});
        end
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        #1;
        check_idle_outputs("reset");
        checks++;
        if (sram_addr !== 18'h00000 || rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_regs: addr=%h rd_data=%h, required 00000/0000", sram_addr, rd_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int oe_cnt = 0;
        int v_cnt  = 0;
        int v_at   = 0;
        mem[18'h00010] = 16'hBEEF;
        tick();
        rd_addr = 18'h00010;
        rd_req  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (!sram_oe_n) begin
                oe_cnt++;
                checks++;
                if (sram_addr !== 18'h00010) begin
                    failures++;
                    $display("FAIL read_addr: got %h, required 00010", sram_addr);
                end
            end
            if (rd_valid) begin
                v_cnt++;
                if (v_at == 0) v_at = i;
                rd_req = 1'b0;
                checks++;
                if (rd_data !== 16'hBEEF) begin
                    failures++;
                    $display("FAIL read_data: got %h, required beef", rd_data);
                end
            end
        end
        checks++;
        if (oe_cnt != 2) begin failures++; $display("FAIL read_oe_cycles: got %0d, required 2", oe_cnt); end
        checks++;
        if (v_cnt != 1) begin failures++; $display("FAIL read_valid_cycles: got %0d, required 1", v_cnt); end
        checks++;
        if (v_at != 3) begin failures++; $display("FAIL read_latency: got %0d, required 3", v_at); end
        checks++;
        if (rd_data !== 16'hBEEF || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_hold: rd_data=%h busy=%b, required beef/0", rd_data, busy);
        end
    endtask

    task automatic test_single_write();
        int we_cnt  = 0;
        int ack_cnt = 0;
        int ack_at  = 0;
        tick();
        wr_addr = 18'h3FFFF;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (!sram_we_n) begin
                we_cnt++;
                checks++;
                if (sram_dq_o !== 16'h1234 || sram_dq_oe !== 1'b1 || sram_addr !== 18'h3FFFF) begin
                    failures++;
                    $display("FAIL write_bus: dq_o=%h dq_oe=%b addr=%h, required 1234/1/3ffff",
                             sram_dq_o, sram_dq_oe, sram_addr);
                end
            end
            if (wr_ack) begin
                ack_cnt++;
                if (ack_at == 0) ack_at = i;
                wr_req = 1'b0;
            end
            if (i == 3) begin
                checks++;
                if (sram_dq_oe !== 1'b1) begin failures++; $display("FAIL write_rec_dq_oe: got %b, required 1", sram_dq_oe); end
            end
            if (i == 4) begin
                checks++;
                if (sram_dq_oe !== 1'b0) begin failures++; $display("FAIL write_idle_dq_oe: got %b, required 0", sram_dq_oe); end
            end
        end
        checks++;
        if (we_cnt != 2) begin failures++; $display("FAIL write_we_cycles: got %0d, required 2", we_cnt); end
        checks++;
        if (ack_cnt != 1) begin failures++; $display("FAIL write_ack_cycles: got %0d, required 1", ack_cnt); end
        checks++;
        if (ack_at != 3) begin failures++; $display("FAIL write_latency: got %0d, required 3", ack_at); end
        checks++;
        if (mem[18'h3FFFF] !== 16'h1234) begin
            failures++;
            $display("FAIL write_mem: got %h, required 1234", mem[18'h3FFFF]);
        end
    endtask

    task automatic test_contention();
        string exp_s;
        int    wcount = 0;
        exp_s = "RRWRRW";
        wait_idle();
        tick();
        grants.delete();
        rd_addr = 18'h00300;
        wr_addr = 18'h00100;
        wr_data = 16'hA000;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd_valid) rd_addr = rd_addr + 18'd1;
            if (wr_ack) begin
                wcount++;
                if (wcount >= 2) begin
                    wr_req = 1'b0;
                end else begin
                    wr_addr = wr_addr + 18'd1;
                    wr_data = wr_data + 16'd1;
                end
            end
            if (grants.size() >= 6) rd_req = 1'b0;
            if (wcount >= 2) break;
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_idle();
        tick();
        checks++;
        if (grants.size() != 6) begin
            failures++;
            $display("FAIL contention_count: got %0d grants, required 6", grants.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < grants.size()) begin
                checks++;
                if (grants[i] !== exp_s[i]) begin
                    failures++;
                    $display("FAIL contention_order[%0d]: got %c, required %c", i, grants[i], exp_s[i]);
                end
            end
        end
        checks++;
        if (mem[18'h00100] !== 16'hA000 || mem[18'h00101] !== 16'hA001) begin
            failures++;
            $display("FAIL contention_writes: got %h/%h, required a000/a001", mem[18'h00100], mem[18'h00101]);
        end
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        int          vt[4];
        logic [15:0] exp_d;
        for (int k = 0; k < 4; k++) mem[18'h00200 + 18'(k)] = 16'hC000 + 16'(k);
        wait_idle();
        tick();
        rd_addr = 18'h00200;
        rd_req  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rd_valid && n < 4) begin
                exp_d = 16'hC000 + 16'(n);
                checks++;
                if (rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: got %h, required %h", n, rd_data, exp_d);
                end
                vt[n] = i;
                n++;
                if (n == 4) rd_req = 1'b0;
                else rd_addr = rd_addr + 18'd1;
            end
            if (n == 4) break;
        end
        rd_req = 1'b0;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d reads, required 4", n);
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (vt[k] - vt[k-1] != 4) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 4", k, vt[k] - vt[k-1]);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_write();
        int ack_seen = 0;
        wait_idle();
        tick();
        wr_addr = 18'h00050;
        wr_data = 16'h5555;
        wr_req  = 1'b1;
        tick();
        checks++;
        if (sram_we_n !== 1'b0) begin failures++; $display("FAIL rstwr_in_write: we_n=%b, required 0", sram_we_n); end
        reset = 1'b1;
        #1;
        check_idle_outputs("rstwr");
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack) ack_seen++;
        end
        checks++;
        if (ack_seen != 0) begin failures++; $display("FAIL rstwr_no_ack: got %0d acks, required 0", ack_seen); end
        check_idle_outputs("rstwr_after");
    endtask

    initial begin
        reset   = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_addr = 18'h00000;
        wr_addr = 18'h00000;
        wr_data = 16'h0000;
        #1;
        reset = 1'b1;
        #20;
        @(negedge clk);
        reset = 1'b0;

        test_single_read();
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_reset_write();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the single asynchronous 16-bit SRAM between two requesters: the record path (ADC samples, writes) and the playback path (DAC samples, reads).
- Sits between the codec datapath and the SRAM pins.
- Generates registered, glitch-free SRAM control strobes with fixed access timing.
- Read has priority, so playback does not underrun; a starvation guard ensures writes still complete.

Parameters:
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: SRAM data width.
- RD_WAIT, 2: cycles OE is held low before data is sampled; must be ≥1.
- WR_WAIT, 2: cycles WE is held low with data driven; must be ≥1.
- MAX_SKIP, 2: consecutive write deferrals allowed before a write is forced. 0 means a pending write always wins.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- rd_req  in  1  playback read request; level, held until rd_valid.
- rd_addr  in  ADDR_W  read address; stable while rd_req is high.
- rd_data  out  DATA_W  read data; valid while rd_valid is high, held afterwards.
- rd_valid  out  1  one-cycle pulse that completes a read (also serves as its ack).
- wr_req  in  1  record write request; level, held until wr_ack.
- wr_addr  in  ADDR_W  write address; stable while wr_req is high.
- wr_data  in  DATA_W  write data; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse that completes a write.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_i  in  DATA_W  SRAM data in, from the top-level tristate.
- sram_dq_o  out  DATA_W  SRAM data out.
- sram_dq_oe  out  1  drive enable for the top-level tristate.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous):
  - All *_n strobes = 1.
  - sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0.
  - rd_data = 0, rd_valid = 0, wr_ack = 0, busy = 0.
  - skip_cnt = 0; state = IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, READ, WRITE, REC.
- IDLE arbitration, sampled at each edge:
  - Only rd_req: grant read.
  - Only wr_req: grant write.
  - Both:
    - If skip_cnt == MAX_SKIP, grant write and clear skip_cnt.
    - Otherwise grant read and increment skip_cnt (saturating).
  - Any write grant clears skip_cnt.
  - A read grant while wr_req is low leaves skip_cnt unchanged.
- READ:
  - The grant edge latches rd_addr into sram_addr and drives ce_n = oe_n = lb_n = ub_n = 0, sram_dq_oe = 0.
  - Lasts exactly RD_WAIT cycles, with a down-counter loaded to RD_WAIT-1.
  - Closing edge: rd_data <= sram_dq_i, rd_valid <= 1, all strobes to 1, state -> REC.
- WRITE:
  - The grant edge latches wr_addr and wr_data and drives ce_n = we_n = lb_n = ub_n = 0, sram_dq_oe = 1.
  - Lasts exactly WR_WAIT cycles.
  - Closing edge: we_n and ce_n to 1, wr_ack <= 1, state -> REC.
  - sram_dq_oe and sram_dq_o stay valid through REC (data hold after WE rises).
- REC:
  - One cycle; all strobes inactive.
  - sram_dq_oe drops at the closing edge.
  - Next state is IDLE.
  - rd_valid and wr_ack are high only during REC.
- Handshake and latency:
  - The requester drops req at the edge that ends the ack cycle, so the following IDLE cycle never re-grants the same transfer.
  - A request seen at grant edge E0 completes with its ack high in the cycle after edge E0+RD_WAIT (or E0+WR_WAIT).
  - Back-to-back read throughput: one transfer per RD_WAIT+2 cycles.
- The OE and WE strobes are never low simultaneously.
- sram_dq_oe is never 1 while sram_oe_n is 0.
- A req that drops before it is granted is ignored; no transfer occurs.
- Reset mid-operation:
  - Strobes deassert immediately (asynchronously) and the FSM goes to IDLE.
  - No ack is issued.
  - An interrupted write may corrupt that one word; this is accepted.

Decomposition:
- Package sram_arb_pkg:
  - State enum (IDLE, READ, WRITE, REC).
  - Default ADDR_W/DATA_W constants.
  - Width of the wait counter, $clog2(max(RD_WAIT, WR_WAIT)).
- No sub-module; a single FSM plus output registers.
- The tristate buffer remains at the top level.

Test Plan:
- Reset: assert reset mid-idle -> all *_n = 1, sram_dq_oe = 0, rd_valid = 0, wr_ack = 0, busy = 0 with no clock edge needed.
- Single read, RD_WAIT = 2:
  - Stimulus: rd_req with rd_addr = 0x00010; model returns 0xBEEF.
  - Expect: oe_n low for exactly 2 cycles, sram_addr = 0x00010, rd_valid high 1 cycle in REC, rd_data = 0xBEEF.
- Single write, WR_WAIT = 2:
  - Stimulus: wr_addr = 0x3FFFF, wr_data = 0x1234.
  - Expect: we_n low for 2 cycles, dq_oe high through REC, wr_ack 1 cycle, model memory[0x3FFFF] = 0x1234.
- Contention, MAX_SKIP = 2:
  - Stimulus: rd_req and wr_req both held continuously.
  - Expect grant order R, R, W, R, R, W; skip_cnt never exceeds 2; no lost write.
- Back-to-back reads with no idle gaps from the requester -> one rd_valid every 4 cycles (RD_WAIT = 2).
- Reset during WRITE:
  - Stimulus: assert reset in the first WRITE cycle.
  - Expect: we_n = 1 and dq_oe = 0 immediately, no wr_ack; after release, IDLE with busy = 0.
